icache_2way: RTL and testbench



---
 rtl/icache_pkg.sv | 20 ++
 rtl/icache_way.sv | 66 ++++++
 rtl/icache_2way.sv | 195 +++++++++++++++++++
 tb/tb_icache_2way.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// ---------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the two-way instruction cache.
//   ADDR_W_DEF : default byte address width of fetch and memory ports
//   SET_W_DEF  : default log2 of the number of sets
//   INST_W     : instruction width held in each cache line
//   state_e    : refill engine state (IDLE = lookup, FILL = byte refill)
// ---------------------------------------------------------------------------
package icache_pkg;

    localparam int ADDR_W_DEF = 17;
    localparam int SET_W_DEF  = 7;
    localparam int INST_W     = 32;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

endpackage

// File: rtl/icache_way.sv
// ---------------------------------------------------------------------------
// icache_way
// One way of the instruction cache: a valid bit per set, plus tag and
// instruction storage. Reads are combinational; there is one write port.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset (clears valid)
//   flush_i        : clears every valid bit at the clock edge
//   rd_set_i       : set index to read
//   rd_valid_o     : valid bit of the addressed set
//   rd_tag_o       : stored tag of the addressed set
//   rd_data_o      : stored instruction of the addressed set
//   wr_en_i        : write tag/data and set valid for wr_set_i
//   wr_set_i       : set index to write
//   wr_tag_i       : tag to store
//   wr_data_i      : instruction to store
// ---------------------------------------------------------------------------
module icache_way
    import icache_pkg::*;
#(
    parameter int SET_W = SET_W_DEF,
    parameter int TAG_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [SET_W-1:0]  rd_set_i,
    output logic              rd_valid_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [INST_W-1:0] rd_data_o,
    input  logic              wr_en_i,
    input  logic [SET_W-1:0]  wr_set_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [INST_W-1:0] wr_data_i
);

    localparam int NUM_SETS = 1 << SET_W;

    logic [NUM_SETS-1:0] valid_q;
    logic [TAG_W-1:0]    tagMem  [NUM_SETS];
    logic [INST_W-1:0]   dataMem [NUM_SETS];

    // Valid bits are the only state that needs a defined reset value; flush
    // takes priority over a same-cycle write so an aborted line never appears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_set_i] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset so they can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tagMem[wr_set_i]  <= wr_tag_i;
            dataMem[wr_set_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_set_i];
    assign rd_tag_o   = tagMem[rd_set_i];
    assign rd_data_o  = dataMem[rd_set_i];

endmodule

// File: rtl/icache_2way.sv
// ---------------------------------------------------------------------------
// icache_2way
// Two-way set-associative instruction cache with a byte-wide refill engine
// and per-set LRU replacement.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   req_i        : fetch request from IF at req_addr_i
//   req_addr_i   : fetch byte address (bits [1:0] ignored)
//   rsp_valid_o  : same-cycle hit; rsp_inst_o holds the instruction
//   rsp_inst_o   : hit instruction, zero when there is no hit
//   busy_o       : refill in progress
//   flush_i      : invalidate all lines, clear LRU, abort any refill
//   mem_req_o    : byte read request to the memory arbiter
//   mem_addr_o   : byte address of the outstanding read
//   mem_ack_i    : memory returns mem_data_i this cycle
//   mem_data_i   : returned byte
// ---------------------------------------------------------------------------
module icache_2way
    import icache_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int SET_W  = SET_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              rsp_valid_o,
    output logic [INST_W-1:0] rsp_inst_o,
    output logic              busy_o,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [7:0]        mem_data_i
);

    localparam int TAG_W    = ADDR_W - SET_W - 2;
    localparam int WORD_W   = ADDR_W - 2;
    localparam int NUM_SETS = 1 << SET_W;

    state_e              state_q;
    logic [1:0]          byteCnt_q;
    logic [WORD_W-1:0]   fillWord_q;
    logic [23:0]         byteBuf_q;
    logic                memReq_q;
    logic [ADDR_W-1:0]   memAddr_q;
    logic                busy_q;
    logic [NUM_SETS-1:0] lru_q;

    logic [SET_W-1:0]  reqSet;
    logic [TAG_W-1:0]  reqTag;
    logic [SET_W-1:0]  fillSet;
    logic [TAG_W-1:0]  fillTag;
    logic [SET_W-1:0]  rdSet;
    logic              valid0, valid1;
    logic [TAG_W-1:0]  tag0, tag1;
    logic [INST_W-1:0] data0, data1;
    logic              hit0, hit1, anyHit;
    logic              lookupEn;
    logic              victim;
    logic              fillDone;
    logic [INST_W-1:0] fillData;
    logic              wrEn0, wrEn1;
    logic              unusedAddrBits;

    assign reqSet  = req_addr_i[SET_W+1:2];
    assign reqTag  = req_addr_i[ADDR_W-1:SET_W+2];
    assign fillSet = fillWord_q[SET_W-1:0];
    assign fillTag = fillWord_q[WORD_W-1:SET_W];

    assign unusedAddrBits = ^req_addr_i[1:0];

    // The single read port follows the fetch address while idle and the
    // latched fill set while refilling, so victim choice sees the fill set.
    assign rdSet = (state_q == FILL) ? fillSet : reqSet;

    icache_way #(
        .SET_W (SET_W),
        .TAG_W (TAG_W)
    ) uWay0 (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .rd_set_i   (rdSet),
        .rd_valid_o (valid0),
        .rd_tag_o   (tag0),
        .rd_data_o  (data0),
        .wr_en_i    (wrEn0),
        .wr_set_i   (fillSet),
        .wr_tag_i   (fillTag),
        .wr_data_i  (fillData)
    );

    icache_way #(
        .SET_W (SET_W),
        .TAG_W (TAG_W)
    ) uWay1 (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .rd_set_i   (rdSet),
        .rd_valid_o (valid1),
        .rd_tag_o   (tag1),
        .rd_data_o  (data1),
        .wr_en_i    (wrEn1),
        .wr_set_i   (fillSet),
        .wr_tag_i   (fillTag),
        .wr_data_i  (fillData)
    );

    // Lookups only happen in IDLE; during FILL the read port is pointed at
    // the fill set, so tag compares there would be meaningless anyway.
    assign lookupEn = (state_q == IDLE) && req_i;
    assign hit0     = valid0 && (tag0 == reqTag);
    assign hit1     = valid1 && (tag1 == reqTag);
    assign anyHit   = hit0 || hit1;

    assign rsp_valid_o = lookupEn && anyHit;
    assign rsp_inst_o  = !lookupEn ? '0 :
                         hit0      ? data0 :
                         hit1      ? data1 : '0;

    // Fill empty ways first; only when both are valid does LRU decide.
    assign victim = !valid0 ? 1'b0 :
                    !valid1 ? 1'b1 : lru_q[fillSet];

    // A flush in the same cycle as the last byte abandons the line.
    assign fillDone = (state_q == FILL) && mem_ack_i && (byteCnt_q == 2'd3) && !flush_i;
    assign fillData = {mem_data_i, byteBuf_q};
    assign wrEn0    = fillDone && !victim;
    assign wrEn1    = fillDone && victim;

    assign busy_o     = busy_q;
    assign mem_req_o  = memReq_q;
    assign mem_addr_o = memAddr_q;

    // Refill FSM with registered memory-side outputs. Bytes shift into the
    // top of byteBuf_q so after three acks it holds {b2,b1,b0} and the fourth
    // byte completes the little-endian word directly from mem_data_i.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            byteCnt_q  <= 2'd0;
            fillWord_q <= '0;
            byteBuf_q  <= '0;
            memReq_q   <= 1'b0;
            memAddr_q  <= '0;
            busy_q     <= 1'b0;
            lru_q      <= '0;
        end else if (flush_i) begin
            state_q   <= IDLE;
            byteCnt_q <= 2'd0;
            memReq_q  <= 1'b0;
            memAddr_q <= '0;
            busy_q    <= 1'b0;
            lru_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i && !anyHit) begin
                        fillWord_q <= req_addr_i[ADDR_W-1:2];
                        byteCnt_q  <= 2'd0;
                        memReq_q   <= 1'b1;
                        memAddr_q  <= {req_addr_i[ADDR_W-1:2], 2'b00};
                        busy_q     <= 1'b1;
                        state_q    <= FILL;
                    end else if (rsp_valid_o) begin
                        lru_q[reqSet] <= hit0;
                    end
                end
                FILL: begin
                    if (mem_ack_i) begin
                        byteBuf_q <= {mem_data_i, byteBuf_q[23:8]};
                        if (byteCnt_q == 2'd3) begin
                            lru_q[fillSet] <= ~victim;
                            byteCnt_q      <= 2'd0;
                            memReq_q       <= 1'b0;
                            memAddr_q      <= '0;
                            busy_q         <= 1'b0;
                            state_q        <= IDLE;
                        end else begin
                            byteCnt_q <= byteCnt_q + 2'd1;
                            memAddr_q <= {fillWord_q, byteCnt_q + 2'd1};
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_2way.sv
// ---------------------------------------------------------------------------
// tb_icache_2way
// Self-checking bench for icache_2way. A memory responder process answers
// byte reads from a fixed memory image; fetch results are pushed to a
// scoreboard queue when a fetch is issued and popped when rsp_valid_o rises.
// ---------------------------------------------------------------------------
module tb_icache_2way;

    localparam int ADDR_W = 17;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_i = 1'b0;
    logic [ADDR_W-1:0] req_addr_i = '0;
    logic              rsp_valid_o;
    logic [31:0]       rsp_inst_o;
    logic              busy_o;
    logic              flush_i;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_ack_i;
    logic [7:0]        mem_data_i;

    int total = 0;
    int bad   = 0;

    logic [31:0]       expQ[$];
    int                stallCycles = 0;
    bit                flushOnLast = 1'b0;
    logic [ADDR_W-1:0] fillAddrExp = '0;
    int                waitCnt = 0;
    int                byteIdx = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                lat;
    } vec_t;

    vec_t vecs[14];

    icache_2way #(
        .ADDR_W (17),
        .SET_W  (7)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .req_addr_i  (req_addr_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_inst_o  (rsp_inst_o),
        .busy_o      (busy_o),
        .flush_i     (flush_i),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ack_i   (mem_ack_i),
        .mem_data_i  (mem_data_i)
    );

    always #5 clk = ~clk;

    // Memory image: a known instruction at 0x104, a hashed pattern elsewhere.
    function automatic logic [7:0] memByte(input logic [ADDR_W-1:0] a);
        logic [7:0] lo;
        case (a)
            17'h00104: return 8'h13;
            17'h00105: return 8'h05;
            17'h00106: return 8'h00;
            17'h00107: return 8'h00;
            default: begin
                lo = a[7:0];
                return (lo * 8'd29) + a[15:8] + 8'h3C;
            end
        endcase
    endfunction

    function automatic logic [31:0] expWord(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] w;
        w = {a[ADDR_W-1:2], 2'b00};
        return {memByte(w + 17'd3), memByte(w + 17'd2), memByte(w + 17'd1), memByte(w)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [ADDR_W-1:0] a);
        req_i      = r;
        req_addr_i = a;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one fetch and hold it until the response arrives; expLat is the
    // cycle count from the request cycle to the hit cycle.
    task automatic fetch(input logic [ADDR_W-1:0] a, input int expLat);
        int cyc;
        bit done;
        cyc  = 0;
        done = 1'b0;
        expQ.push_back(expWord(a));
        fillAddrExp = a;
        applyStimulus(1'b1, a);
        while (!done && cyc < 300) begin
            @(negedge clk);
            if (rsp_valid_o) begin
                checkOutput("rspInst", rsp_inst_o, expQ.pop_front());
                checkOutput("latency", 32'(cyc), 32'(expLat));
                done = 1'b1;
            end else begin
                checkOutput("busyWhileWaiting", 32'(busy_o), (cyc > 0) ? 32'd1 : 32'd0);
            end
            stepCycle();
            if (!done) cyc++;
        end
        if (!done) begin
            checkOutput("fetchTimeout", 32'd0, 32'd1);
            void'(expQ.pop_front());
        end
        applyStimulus(1'b0, a);
    endtask

    // Memory responder: acks the first byte immediately and then waits
    // stallCycles idle cycles before each following ack.
    initial begin
        mem_ack_i  = 1'b0;
        mem_data_i = 8'h00;
        flush_i    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack_i = 1'b0;
            flush_i   = 1'b0;
            if (!mem_req_o) begin
                waitCnt = 0;
                byteIdx = 0;
            end else begin
                checkOutput("memAddr", 32'(mem_addr_o), 32'({fillAddrExp[ADDR_W-1:2], byteIdx[1:0]}));
                if (waitCnt == 0) begin
                    mem_ack_i  = 1'b1;
                    mem_data_i = memByte(mem_addr_o);
                    if (byteIdx == 3 && flushOnLast) begin
                        flush_i     = 1'b1;
                        flushOnLast = 1'b0;
                    end
                    byteIdx++;
                    waitCnt = stallCycles;
                end else begin
                    waitCnt--;
                end
            end
        end
    end

    initial begin
        // Hits, conflicts and LRU-driven evictions within set 0x41, plus set 2.
        vecs[0]  = '{17'h00104, 5};
        vecs[1]  = '{17'h00104, 0};
        vecs[2]  = '{17'h00304, 5};
        vecs[3]  = '{17'h00304, 0};
        vecs[4]  = '{17'h00104, 0};
        vecs[5]  = '{17'h00504, 5};
        vecs[6]  = '{17'h00104, 0};
        vecs[7]  = '{17'h00304, 5};
        vecs[8]  = '{17'h00008, 5};
        vecs[9]  = '{17'h00008, 0};
        vecs[10] = '{17'h00504, 5};
        vecs[11] = '{17'h00304, 0};
        vecs[12] = '{17'h00104, 5};
        vecs[13] = '{17'h00304, 0};

        // Reset values while a request is presented.
        applyStimulus(1'b1, 17'h00104);
        @(negedge clk);
        checkOutput("rstRspValid", 32'(rsp_valid_o), 32'd0);
        checkOutput("rstRspInst", rsp_inst_o, 32'd0);
        checkOutput("rstBusy", 32'(busy_o), 32'd0);
        checkOutput("rstMemReq", 32'(mem_req_o), 32'd0);
        checkOutput("rstMemAddr", 32'(mem_addr_o), 32'd0);
        stepCycle();
        applyStimulus(1'b0, '0);
        rst = 1'b0;
        stepCycle();

        $display("[TB] table-driven fetch sequence");
        for (int i = 0; i < 14; i++) begin
            fetch(vecs[i].addr, vecs[i].lat);
        end

        $display("[TB] ack stalls");
        stallCycles = 2;
        fetch(17'h00700, 11);
        stallCycles = 0;
        fetch(17'h00700, 0);

        $display("[TB] redirect during fill");
        fillAddrExp = 17'h00408;
        applyStimulus(1'b1, 17'h00408);
        @(negedge clk);
        checkOutput("redirMiss", 32'(rsp_valid_o), 32'd0);
        stepCycle();
        applyStimulus(1'b1, 17'h00008);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checkOutput("redirNoRspInFill", 32'(rsp_valid_o), 32'd0);
            checkOutput("redirBusy", 32'(busy_o), 32'd1);
            stepCycle();
        end
        expQ.push_back(expWord(17'h00008));
        @(negedge clk);
        checkOutput("redirHitValid", 32'(rsp_valid_o), 32'd1);
        checkOutput("redirHitInst", rsp_inst_o, expQ.pop_front());
        stepCycle();
        applyStimulus(1'b0, '0);
        fetch(17'h00408, 0);

        $display("[TB] flush on last ack");
        fillAddrExp = 17'h00204;
        flushOnLast = 1'b1;
        applyStimulus(1'b1, 17'h00204);
        @(negedge clk);
        checkOutput("flushMiss", 32'(rsp_valid_o), 32'd0);
        stepCycle();
        applyStimulus(1'b0, '0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checkOutput("flushBusy", 32'(busy_o), 32'd1);
            stepCycle();
        end
        @(negedge clk);
        checkOutput("flushIdleBusy", 32'(busy_o), 32'd0);
        checkOutput("flushIdleMemReq", 32'(mem_req_o), 32'd0);
        stepCycle();
        fetch(17'h00204, 5);
        fetch(17'h00104, 5);
        fetch(17'h00008, 5);

        $display("[TB] reset during fill");
        fillAddrExp = 17'h00604;
        applyStimulus(1'b1, 17'h00604);
        stepCycle();
        applyStimulus(1'b1, 17'h00104);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midRstBusy", 32'(busy_o), 32'd0);
        checkOutput("midRstMemReq", 32'(mem_req_o), 32'd0);
        checkOutput("midRstMemAddr", 32'(mem_addr_o), 32'd0);
        checkOutput("midRstRspValid", 32'(rsp_valid_o), 32'd0);
        checkOutput("midRstRspInst", rsp_inst_o, 32'd0);
        stepCycle();
        rst = 1'b0;
        applyStimulus(1'b0, '0);
        stepCycle();
        fetch(17'h00104, 5);
        fetch(17'h00604, 5);
        fetch(17'h00104, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
